// File: rtl/mobo_readout_fsm_pkg.sv
// ---------------------------------------------------------------------------
// mobo_readout_fsm_pkg
// Shared definitions for the motherboard readout sequencer:
//   - rd_state_e : one-hot state encoding of the 12-state readout FSM
//   - STAT_*     : debug codes reported on rd_stat
//   - CDS_*      : phase tags carried on CDS_PH alongside ADC_RD
//   - stat_code(): maps a state to its rd_stat code
// ---------------------------------------------------------------------------
package mobo_readout_fsm_pkg;

  typedef enum logic [11:0] {
    ST_IDLE       = 12'b0000_0000_0001,
    ST_ROW_SETUP  = 12'b0000_0000_0010,
    ST_SETTLE     = 12'b0000_0000_0100,
    ST_CONV_SIG   = 12'b0000_0000_1000,
    ST_WAIT_SIG   = 12'b0000_0001_0000,
    ST_ROW_RST    = 12'b0000_0010_0000,
    ST_RST_SETTLE = 12'b0000_0100_0000,
    ST_CONV_RST   = 12'b0000_1000_0000,
    ST_WAIT_RST   = 12'b0001_0000_0000,
    ST_NEXT_ROW   = 12'b0010_0000_0000,
    ST_HAND_BACK  = 12'b0100_0000_0000,
    ST_WAIT_ACK0  = 12'b1000_0000_0000
  } rd_state_e;

  localparam logic [7:0] STAT_RESET      = 8'hA5;
  localparam logic [7:0] STAT_ILLEGAL    = 8'h00;
  localparam logic [7:0] STAT_IDLE       = 8'h01;
  localparam logic [7:0] STAT_ROW_SETUP  = 8'h02;
  localparam logic [7:0] STAT_SETTLE     = 8'h03;
  localparam logic [7:0] STAT_CONV_SIG   = 8'h04;
  localparam logic [7:0] STAT_WAIT_SIG   = 8'h05;
  localparam logic [7:0] STAT_ROW_RST    = 8'h06;
  localparam logic [7:0] STAT_RST_SETTLE = 8'h07;
  localparam logic [7:0] STAT_CONV_RST   = 8'h08;
  localparam logic [7:0] STAT_WAIT_RST   = 8'h09;
  localparam logic [7:0] STAT_NEXT_ROW   = 8'h0A;
  localparam logic [7:0] STAT_HAND_BACK  = 8'h0B;
  localparam logic [7:0] STAT_WAIT_ACK0  = 8'h0C;

  localparam logic CDS_SIG = 1'b0;
  localparam logic CDS_RST = 1'b1;

  // Settling time after the pixel row-reset pulse is fixed, not a parameter.
  localparam int unsigned C_RST_SETTLE_CYC = 4;

  function automatic logic [7:0] stat_code(input rd_state_e st);
    logic [7:0] code;
    case (st)
      ST_IDLE:       code = STAT_IDLE;
      ST_ROW_SETUP:  code = STAT_ROW_SETUP;
      ST_SETTLE:     code = STAT_SETTLE;
      ST_CONV_SIG:   code = STAT_CONV_SIG;
      ST_WAIT_SIG:   code = STAT_WAIT_SIG;
      ST_ROW_RST:    code = STAT_ROW_RST;
      ST_RST_SETTLE: code = STAT_RST_SETTLE;
      ST_CONV_RST:   code = STAT_CONV_RST;
      ST_WAIT_RST:   code = STAT_WAIT_RST;
      ST_NEXT_ROW:   code = STAT_NEXT_ROW;
      ST_HAND_BACK:  code = STAT_HAND_BACK;
      ST_WAIT_ACK0:  code = STAT_WAIT_ACK0;
      default:       code = STAT_ILLEGAL;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/mobo_readout_fsm_hs_sync2.sv
// ---------------------------------------------------------------------------
// hs_sync2
// Two-flop synchronizer for a single asynchronous level, reset value 0.
//   CLK_ADC : destination clock
//   RESET   : synchronous, active-high
//   d       : asynchronous level
//   q       : level synchronized to CLK_ADC (2-cycle latency)
// ---------------------------------------------------------------------------
module hs_sync2 (
  input  logic CLK_ADC,
  input  logic RESET,
  input  logic d,
  output logic q
);

  logic meta_r;

  // Two-stage capture of the asynchronous level.
  always_ff @(posedge CLK_ADC) begin
    if (RESET) begin
      meta_r <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_r <= d;
      q      <= meta_r;
    end
  end

endmodule

// File: rtl/mobo_readout_fsm.sv
// ---------------------------------------------------------------------------
// mobo_readout_fsm
// Motherboard readout sequencer. On "exposure done" (FSMIND1) it scans every
// pixel row with correlated double sampling (signal conversion, row reset,
// reset conversion), then hands control back via FSMIND0.
// Ports:
//   CLK_ADC, RESET          : clock, synchronous active-high reset
//   FSMIND1 / FSMIND1ACK    : exposure-done request and its acknowledge
//   FSMIND0 / FSMIND0ACK    : readout-done hand-back and its acknowledge
//   DOUT_AFULL              : downstream FIFO almost full (stalls new conversions)
//   ROW_ADDR, ROW_SEL       : row address and row select
//   PIXRES_ROW              : row reset pulse for the CDS reset sample
//   ADC_CNV, ADC_RD, CDS_PH : conversion start, capture strobe, phase tag
//   FRAME_CNT               : completed frames (wraps)
//   rd_stat                 : debug code of the state active one cycle earlier
// ---------------------------------------------------------------------------
module mobo_readout_fsm
  import mobo_readout_fsm_pkg::*;
#(
  parameter int unsigned C_NUM_ROWS   = 160,
  parameter int unsigned C_SETTLE_CYC = 8,
  parameter int unsigned C_RST_CYC    = 4,
  parameter int unsigned C_CONV_CYC   = 20
) (
  input  logic        CLK_ADC,
  input  logic        RESET,
  input  logic        FSMIND1,
  input  logic        FSMIND0ACK,
  input  logic        DOUT_AFULL,
  output logic        FSMIND1ACK,
  output logic        FSMIND0,
  output logic [7:0]  ROW_ADDR,
  output logic        ROW_SEL,
  output logic        PIXRES_ROW,
  output logic        ADC_CNV,
  output logic        ADC_RD,
  output logic        CDS_PH,
  output logic [31:0] FRAME_CNT,
  output logic [7:0]  rd_stat
);

  // Terminal counts; WAIT states last C_CONV_CYC+1 cycles so that the
  // ADC_CNV-to-ADC_RD distance is exactly C_CONV_CYC+1.
  localparam logic [15:0] SETTLE_LAST     = 16'(C_SETTLE_CYC - 1);
  localparam logic [15:0] RST_LAST        = 16'(C_RST_CYC - 1);
  localparam logic [15:0] RST_SETTLE_LAST = 16'(C_RST_SETTLE_CYC - 1);
  localparam logic [15:0] CONV_LAST       = 16'(C_CONV_CYC);
  localparam logic [7:0]  ROW_LAST        = 8'(C_NUM_ROWS - 1);

  rd_state_e   state_r;
  logic [15:0] cnt_r;
  logic [7:0]  row_r;
  logic        ind1_sync_s;
  logic        ind0ack_sync_s;

  hs_sync2 u_sync_ind1 (
    .CLK_ADC (CLK_ADC),
    .RESET   (RESET),
    .d       (FSMIND1),
    .q       (ind1_sync_s)
  );

  hs_sync2 u_sync_ind0ack (
    .CLK_ADC (CLK_ADC),
    .RESET   (RESET),
    .d       (FSMIND0ACK),
    .q       (ind0ack_sync_s)
  );

  // Readout sequencer: state, counters and all registered outputs.
  always_ff @(posedge CLK_ADC) begin
    if (RESET) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 16'd0;
      row_r      <= 8'd0;
      FSMIND1ACK <= 1'b0;
      FSMIND0    <= 1'b0;
      ROW_ADDR   <= 8'd0;
      ROW_SEL    <= 1'b0;
      PIXRES_ROW <= 1'b0;
      ADC_CNV    <= 1'b0;
      ADC_RD     <= 1'b0;
      CDS_PH     <= 1'b0;
      FRAME_CNT  <= 32'd0;
      rd_stat    <= STAT_RESET;
    end else begin
      // Strobes are single-cycle unless re-armed below.
      ADC_CNV <= 1'b0;
      ADC_RD  <= 1'b0;
      rd_stat <= stat_code(state_r);
      case (state_r)
        ST_IDLE: begin
          if (ind1_sync_s) begin
            FSMIND1ACK <= 1'b1;
            row_r      <= 8'd0;
            state_r    <= ST_ROW_SETUP;
          end
        end
        ST_ROW_SETUP: begin
          ROW_ADDR <= row_r;
          ROW_SEL  <= 1'b1;
          cnt_r    <= 16'd0;
          state_r  <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (cnt_r == SETTLE_LAST) begin
            cnt_r   <= 16'd0;
            state_r <= ST_CONV_SIG;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        ST_CONV_SIG: begin
          if (!DOUT_AFULL) begin
            ADC_CNV <= 1'b1;
            CDS_PH  <= CDS_SIG;
            cnt_r   <= 16'd0;
            state_r <= ST_WAIT_SIG;
          end
        end
        ST_WAIT_SIG: begin
          if (cnt_r == CONV_LAST) begin
            ADC_RD     <= 1'b1;
            PIXRES_ROW <= 1'b1;  // raised on entry so the pulse spans all of ROW_RST
            cnt_r      <= 16'd0;
            state_r    <= ST_ROW_RST;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        ST_ROW_RST: begin
          if (cnt_r == RST_LAST) begin
            PIXRES_ROW <= 1'b0;
            cnt_r      <= 16'd0;
            state_r    <= ST_RST_SETTLE;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        ST_RST_SETTLE: begin
          if (cnt_r == RST_SETTLE_LAST) begin
            cnt_r   <= 16'd0;
            state_r <= ST_CONV_RST;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        ST_CONV_RST: begin
          if (!DOUT_AFULL) begin
            ADC_CNV <= 1'b1;
            CDS_PH  <= CDS_RST;
            cnt_r   <= 16'd0;
            state_r <= ST_WAIT_RST;
          end
        end
        ST_WAIT_RST: begin
          if (cnt_r == CONV_LAST) begin
            ADC_RD  <= 1'b1;
            cnt_r   <= 16'd0;
            state_r <= ST_NEXT_ROW;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        ST_NEXT_ROW: begin
          ROW_SEL <= 1'b0;
          if (row_r < ROW_LAST) begin
            row_r   <= row_r + 8'd1;
            state_r <= ST_ROW_SETUP;
          end else begin
            state_r <= ST_HAND_BACK;
          end
        end
        ST_HAND_BACK: begin
          // ACK drops on the same edge FSMIND0 rises: they never overlap.
          FSMIND1ACK <= 1'b0;
          FSMIND0    <= 1'b1;
          FRAME_CNT  <= FRAME_CNT + 32'd1;
          state_r    <= ST_WAIT_ACK0;
        end
        ST_WAIT_ACK0: begin
          if (ind0ack_sync_s && !ind1_sync_s) begin
            FSMIND0 <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          // Corrupted state register: clear everything and restart idle.
          state_r    <= ST_IDLE;
          cnt_r      <= 16'd0;
          row_r      <= 8'd0;
          FSMIND1ACK <= 1'b0;
          FSMIND0    <= 1'b0;
          ROW_ADDR   <= 8'd0;
          ROW_SEL    <= 1'b0;
          PIXRES_ROW <= 1'b0;
          CDS_PH     <= 1'b0;
          FRAME_CNT  <= 32'd0;
          rd_stat    <= STAT_ILLEGAL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mobo_readout_fsm.sv
// ---------------------------------------------------------------------------
// tb_mobo_readout_fsm
// Directed bench for mobo_readout_fsm: default instance (160 rows, 20-cycle
// conversions) and a small instance (2 rows, 1-cycle conversions).
// Inputs are driven on the falling edge, outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_mobo_readout_fsm;

  localparam int N_ROWS       = 160;
  localparam int SETTLE       = 8;
  localparam int RSTC         = 4;
  localparam int CONV         = 20;
  localparam int ROW_PERIOD   = 1 + SETTLE + 2 * (1 + CONV + 1) + RSTC + 4 + 1;  // 62
  localparam int FRAME_BUDGET = 12000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, ind1, ind0ack, afull;
  logic        FSMIND1ACK, FSMIND0, ROW_SEL, PIXRES_ROW, ADC_CNV, ADC_RD, CDS_PH;
  logic [7:0]  ROW_ADDR, rd_stat;
  logic [31:0] FRAME_CNT;

  logic        s_ind1, s_ind0ack;
  logic        s_ack, s_ind0, s_sel, s_pix, s_cnv, s_rd, s_ph;
  logic [7:0]  s_row, s_stat;
  logic [31:0] s_frame;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  mobo_readout_fsm dut (
    .CLK_ADC(clk), .RESET(reset), .FSMIND1(ind1), .FSMIND0ACK(ind0ack),
    .DOUT_AFULL(afull), .FSMIND1ACK(FSMIND1ACK), .FSMIND0(FSMIND0),
    .ROW_ADDR(ROW_ADDR), .ROW_SEL(ROW_SEL), .PIXRES_ROW(PIXRES_ROW),
    .ADC_CNV(ADC_CNV), .ADC_RD(ADC_RD), .CDS_PH(CDS_PH),
    .FRAME_CNT(FRAME_CNT), .rd_stat(rd_stat)
  );

  mobo_readout_fsm #(.C_NUM_ROWS(2), .C_CONV_CYC(1)) dut_small (
    .CLK_ADC(clk), .RESET(reset), .FSMIND1(s_ind1), .FSMIND0ACK(s_ind0ack),
    .DOUT_AFULL(1'b0), .FSMIND1ACK(s_ack), .FSMIND0(s_ind0),
    .ROW_ADDR(s_row), .ROW_SEL(s_sel), .PIXRES_ROW(s_pix),
    .ADC_CNV(s_cnv), .ADC_RD(s_rd), .CDS_PH(s_ph),
    .FRAME_CNT(s_frame), .rd_stat(s_stat)
  );

  // Free-running cycle counter used for strobe spacing.
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor for the default instance.
  int         cnv_tot = 0, rd_tot = 0, cnv_err = 0, rd_err = 0, pix_err = 0, both_err = 0;
  int         cnv_cyc_r = 0, pix_run_r = 0;
  logic       pend_r = 1'b0, cnv_ph_r = 1'b0;
  logic [7:0] cnv_row_r = 8'd0, exp_row_r = 8'd0;

  always @(negedge clk) begin
    if (reset) begin
      pend_r    <= 1'b0;
      exp_row_r <= 8'd0;
    end else begin
      if (ADC_CNV) begin
        cnv_tot   <= cnv_tot + 1;
        pend_r    <= 1'b1;
        cnv_cyc_r <= cyc;
        cnv_ph_r  <= CDS_PH;
        cnv_row_r <= ROW_ADDR;
        if (CDS_PH == 1'b0)
          exp_row_r <= (ROW_ADDR == 8'(N_ROWS - 1)) ? 8'd0 : ROW_ADDR + 8'd1;
        cnv_err <= cnv_err + int'(pend_r) + int'(!ROW_SEL)
                   + int'(CDS_PH == 1'b0 && ROW_ADDR != exp_row_r)
                   + int'(CDS_PH == 1'b1 && (ROW_ADDR != cnv_row_r || cnv_ph_r != 1'b0));
      end
      if (ADC_RD) begin
        rd_tot <= rd_tot + 1;
        pend_r <= 1'b0;
        rd_err <= rd_err + int'(!pend_r) + int'(CDS_PH != cnv_ph_r)
                  + int'((cyc - cnv_cyc_r) != CONV + 1);
      end
      if (PIXRES_ROW) begin
        pix_run_r <= pix_run_r + 1;
      end else begin
        if (pix_run_r != 0) pix_err <= pix_err + int'(pix_run_r != RSTC);
        pix_run_r <= 0;
      end
      both_err <= both_err + int'(FSMIND0 && FSMIND1ACK);
    end
  end

  // Strobe monitor for the small instance (expected CNV->RD gap is 2).
  int s_cnv_tot = 0, s_rd_tot = 0, s_gap_err = 0, s_cnv_cyc = 0, s_last_gap = 0;

  always @(negedge clk) begin
    if (s_cnv) begin
      s_cnv_tot <= s_cnv_tot + 1;
      s_cnv_cyc <= cyc;
    end
    if (s_rd) begin
      s_rd_tot   <= s_rd_tot + 1;
      s_gap_err  <= s_gap_err + int'((cyc - s_cnv_cyc) != 2);
      s_last_gap <= cyc - s_cnv_cyc;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_checks++;
    if (obs !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, req);
    end
  endtask

  task automatic wait_ind0(input logic val, input int budget, input string tag);
    int n = 0;
    while (FSMIND0 !== val && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (FSMIND0 !== val) check_val({tag, "_timeout"}, 32'(FSMIND0), 32'(val));
  endtask

  // Wait for a CNV (want_rd=0) or RD (want_rd=1) strobe at a given row and phase.
  task automatic wait_strobe(input logic want_rd, input logic [7:0] row, input logic ph,
                             input int budget, output int at_cyc);
    int   n = 0;
    logic found = 1'b0;
    while (!found && n < budget) begin
      if ((want_rd ? ADC_RD : ADC_CNV) && ROW_ADDR == row && CDS_PH == ph) found = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    at_cyc = cyc;
    if (!found) check_val("strobe_timeout", 32'(found), 32'd1);
  endtask

  task automatic run_frame(output logic [7:0] first_row);
    int   n = 0;
    logic got = 1'b0;
    first_row = 8'hFF;
    ind1 = 1'b1;
    while (FSMIND0 !== 1'b1 && n < FRAME_BUDGET) begin
      @(negedge clk);
      n++;
      if (ADC_CNV && !got) begin
        got = 1'b1;
        first_row = ROW_ADDR;
      end
    end
    check_val("frame_done", 32'(FSMIND0), 32'd1);
    ind1    = 1'b0;
    ind0ack = 1'b1;
    wait_ind0(1'b0, 20, "b2b_hb");
    ind0ack = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int         c0, r0, t0, t1, hold_cnv, n;
    logic [7:0] first_row;
    reset = 1'b1; ind1 = 1'b0; ind0ack = 1'b0; afull = 1'b0;
    s_ind1 = 1'b0; s_ind0ack = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check_val("rst_flags", {25'd0, FSMIND1ACK, FSMIND0, ROW_SEL, PIXRES_ROW, ADC_CNV, ADC_RD, CDS_PH}, 32'd0);
    check_val("rst_row", {24'd0, ROW_ADDR}, 32'd0);
    check_val("rst_frame", FRAME_CNT, 32'd0);
    check_val("rst_stat", {24'd0, rd_stat}, 32'h0000_00A5);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_val("idle_stat", {24'd0, rd_stat}, 32'h0000_0001);

    // Small instance: 2 rows, 1-cycle conversions
    s_ind1 = 1'b1;
    n = 0;
    while (s_ind0 !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_val("sm_done", 32'(s_ind0), 32'd1);
    check_val("sm_cnv", 32'(s_cnv_tot), 32'd4);
    check_val("sm_rd", 32'(s_rd_tot), 32'd4);
    check_val("sm_gap_err", 32'(s_gap_err), 32'd0);
    check_val("sm_last_gap", 32'(s_last_gap), 32'd2);
    check_val("sm_frame", s_frame, 32'd1);
    s_ind1 = 1'b0; s_ind0ack = 1'b1;
    repeat (5) @(negedge clk);
    s_ind0ack = 1'b0;

    // Frame 1: latency, row period, strobe counts, hand-back handshake
    c0 = cnv_tot; r0 = rd_tot;
    ind1 = 1'b1;
    repeat (2) @(negedge clk);
    check_val("ack_lat_2", 32'(FSMIND1ACK), 32'd0);
    @(negedge clk);
    check_val("ack_lat_3", 32'(FSMIND1ACK), 32'd1);
    wait_strobe(1'b0, 8'd0, 1'b0, 100, t0);
    wait_strobe(1'b0, 8'd1, 1'b0, 200, t1);
    check_val("row_period", 32'(t1 - t0), 32'(ROW_PERIOD));
    wait_ind0(1'b1, FRAME_BUDGET, "frame1");
    check_val("f1_cnv", 32'(cnv_tot - c0), 32'd320);
    check_val("f1_rd", 32'(rd_tot - r0), 32'd320);
    check_val("f1_frame", FRAME_CNT, 32'd1);
    check_val("f1_last_row", {24'd0, ROW_ADDR}, 32'd159);
    check_val("f1_ack_low", 32'(FSMIND1ACK), 32'd0);
    ind0ack = 1'b1;
    repeat (10) @(negedge clk);
    check_val("hb_hold", 32'(FSMIND0), 32'd1);
    ind1 = 1'b0;
    repeat (2) @(negedge clk);
    check_val("hb_fall_2", 32'(FSMIND0), 32'd1);
    @(negedge clk);
    check_val("hb_fall_3", 32'(FSMIND0), 32'd0);
    ind0ack = 1'b0;
    repeat (3) @(negedge clk);

    // Frame 2: backpressure at row 5 ahead of the reset conversion
    c0 = cnv_tot; r0 = rd_tot;
    ind1 = 1'b1;
    wait_strobe(1'b1, 8'd5, 1'b0, 1000, t0);
    afull = 1'b1;
    hold_cnv = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ADC_CNV) hold_cnv++;
    end
    check_val("bp_no_cnv", 32'(hold_cnv), 32'd0);
    check_val("bp_stat", {24'd0, rd_stat}, 32'h0000_0008);
    afull = 1'b0;
    @(negedge clk);
    check_val("bp_fire", {30'd0, ADC_CNV, CDS_PH}, 32'd3);
    check_val("bp_row", {24'd0, ROW_ADDR}, 32'd5);
    wait_ind0(1'b1, FRAME_BUDGET, "frame2");
    check_val("f2_cnv", 32'(cnv_tot - c0), 32'd320);
    check_val("f2_rd", 32'(rd_tot - r0), 32'd320);
    check_val("f2_frame", FRAME_CNT, 32'd2);
    ind1 = 1'b0; ind0ack = 1'b1;
    wait_ind0(1'b0, 20, "hb2");
    ind0ack = 1'b0;
    repeat (3) @(negedge clk);

    // Reset mid-frame at row 80 while waiting on the signal conversion
    ind1 = 1'b1;
    wait_strobe(1'b0, 8'd80, 1'b0, 6000, t0);
    repeat (2) @(negedge clk);
    check_val("pre_rst_stat", {24'd0, rd_stat}, 32'h0000_0005);
    reset = 1'b1; ind1 = 1'b0;
    c0 = cnv_tot; r0 = rd_tot;
    @(negedge clk);
    check_val("mr_flags", {25'd0, FSMIND1ACK, FSMIND0, ROW_SEL, PIXRES_ROW, ADC_CNV, ADC_RD, CDS_PH}, 32'd0);
    check_val("mr_row", {24'd0, ROW_ADDR}, 32'd0);
    check_val("mr_frame", FRAME_CNT, 32'd0);
    check_val("mr_stat", {24'd0, rd_stat}, 32'h0000_00A5);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    check_val("mr_no_cnv", 32'(cnv_tot - c0), 32'd0);
    check_val("mr_no_rd", 32'(rd_tot - r0), 32'd0);

    // Back-to-back frames after the reset, each starting from row 0
    c0 = cnv_tot; r0 = rd_tot;
    for (int f = 0; f < 3; f++) begin
      run_frame(first_row);
      check_val("b2b_first_row", {24'd0, first_row}, 32'd0);
    end
    check_val("b2b_frame", FRAME_CNT, 32'd3);
    check_val("b2b_cnv", 32'(cnv_tot - c0), 32'd960);
    check_val("b2b_rd", 32'(rd_tot - r0), 32'd960);
    check_val("both_high", 32'(both_err), 32'd0);
    check_val("cnv_seq_err", 32'(cnv_err), 32'd0);
    check_val("rd_seq_err", 32'(rd_err), 32'd0);
    check_val("pixres_width_err", 32'(pix_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
